// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, receive FIFO and framing/overrun reporting.
module uart_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       rx,
    output logic [7:0] o_data,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_frame_err,
    output logic       o_overrun,
    input  logic       i_clr_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n;
    logic          rx_m, rx_s, push, ferr_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wp, rp;
    logic          full, pop, wr;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_m        <= 1'b1;
            rx_s        <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            o_frame_err <= 1'b0;
        end else begin
            rx_m        <= rx;
            rx_s        <= rx_m;
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            shift       <= shift_n;
            o_frame_err <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        push    = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: if (!rx_s) begin
                state_n = START;
                cnt_n   = HALF;
            end
            START: if (cnt != '0) cnt_n = cnt - 1'b1;
                else if (rx_s) state_n = IDLE;
                else begin
                    state_n = DATA;
                    cnt_n   = FULL;
                    idx_n   = 3'd0;
                end
            DATA: if (cnt != '0) cnt_n = cnt - 1'b1;
                else begin
                    shift_n = {rx_s, shift[7:1]};
                    cnt_n   = FULL;
                    idx_n   = idx + 3'd1;
                    state_n = (idx == 3'd7) ? STOP : DATA;
                end
            STOP: if (cnt != '0) cnt_n = cnt - 1'b1;
                else begin
                    state_n = rx_s ? IDLE : WAIT_HIGH;
                    push    = rx_s;
                    ferr_n  = !rx_s;
                end
            WAIT_HIGH: state_n = rx_s ? IDLE : WAIT_HIGH;
            default: state_n = IDLE;
        endcase
    end

    // A pop in the same cycle frees the slot the push needs, so only push-on-full-without-pop drops.
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign o_valid = (wp != rp);
    assign pop     = o_valid && i_ready;
    assign wr      = push && (!full || pop);
    assign o_data  = o_valid ? mem[rp[AW-1:0]] : 8'd0;

    always_ff @(posedge i_clk) begin
        if (wr) mem[wp[AW-1:0]] <= shift;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wp        <= '0;
            rp        <= '0;
            o_overrun <= 1'b0;
        end else begin
            if (wr) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
            o_overrun <= (push && !wr) ? 1'b1 : (i_clr_err ? 1'b0 : o_overrun);
        end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed table-driven and sequence checks for uart_rx (CLKS_PER_BIT=8, FIFO_DEPTH=4).
module tb_uart_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] data;
    logic       valid, ferr, ovr;
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         t0 = 0;
    int         tv = -1;
    int         ferr_cnt = 0;

    uart_rx #(.CLKS_PER_BIT(8), .FIFO_DEPTH(4)) dut (
        .i_clk(clk), .i_rst(rst), .rx(rx), .o_data(data), .o_valid(valid),
        .i_ready(ready), .o_frame_err(ferr), .o_overrun(ovr), .i_clr_err(clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ferr) ferr_cnt <= ferr_cnt + 1;
        if (valid && tv < 0) tv <= cyc;
    end

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       exp_valid;
        logic [7:0] exp_data;
        int         exp_ferr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic stop);
        @(posedge clk);
        #1 rx = 1'b0;
        t0 = cyc;
        repeat (8) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (8) @(posedge clk);
        end
        #1 rx = stop;
        repeat (8) @(posedge clk);
        #1 rx = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic pop_one;
        @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
    endtask

    initial begin
        vec_t vecs[5];
        vecs[0] = '{8'hA5, 1'b1, 1'b1, 8'hA5, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 8'h00, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 0};
        vecs[3] = '{8'h3C, 1'b0, 1'b0, 8'h00, 1};
        vecs[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 0};

        idle(3);
        @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_ferr", ferr, 0);
        chk("rst_ovr", ovr, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(4);

        // latency of the first byte from the start edge
        tv = -1;
        send(8'hA5, 1'b1);
        idle(4);
        chk("latency_ok", (tv - t0 >= 77 && tv - t0 <= 81), 1);
        chk("first_data", data, 8'hA5);
        chk("first_ovr", ovr, 0);
        pop_one();

        for (int i = 0; i < 5; i++) begin
            ferr_cnt = 0;
            send(vecs[i].d, vecs[i].stop);
            idle(4);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), valid, vecs[i].exp_valid);
            chk($sformatf("vec%0d_data", i), data, vecs[i].exp_data);
            chk($sformatf("vec%0d_ferr", i), ferr_cnt, vecs[i].exp_ferr);
            if (valid) pop_one();
        end

        // 3-cycle glitch is rejected as a false start
        ferr_cnt = 0;
        @(posedge clk);
        #1 rx = 1'b0;
        idle(3);
        #1 rx = 1'b1;
        idle(20);
        @(negedge clk);
        chk("glitch_valid", valid, 0);
        chk("glitch_ferr", ferr_cnt, 0);
        send(8'h42, 1'b1);
        idle(4);
        @(negedge clk);
        chk("after_glitch", data, 8'h42);
        pop_one();

        // break: bad stop followed by a long low line gives one pulse only
        ferr_cnt = 0;
        send(8'h3C, 1'b0);
        #1 rx = 1'b0;
        idle(40);
        #1 rx = 1'b1;
        idle(10);
        @(negedge clk);
        chk("break_ferr", ferr_cnt, 1);
        chk("break_valid", valid, 0);

        // overflow: fifth byte dropped
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
        idle(4);
        @(negedge clk);
        chk("ovr_set", ovr, 1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk($sformatf("drain%0d_valid", i), valid, 1);
            chk($sformatf("drain%0d_data", i), data, 8'(i));
            pop_one();
        end
        @(negedge clk);
        chk("drain_empty", valid, 0);
        chk("ovr_sticky", ovr, 1);
        @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        chk("ovr_clr", ovr, 0);

        // full FIFO, pop coincides with the fifth stop sample
        for (int i = 1; i <= 4; i++) send(8'(i), 1'b1);
        fork
            send(8'h05, 1'b1);
            begin
                @(posedge clk);
                repeat (78) @(posedge clk);
                #1 ready = 1'b1;
                @(posedge clk);
                #1 ready = 1'b0;
            end
        join
        idle(4);
        @(negedge clk);
        chk("coinc_ovr", ovr, 0);
        for (int i = 2; i <= 5; i++) begin
            @(negedge clk);
            chk($sformatf("coinc%0d_data", i), data, 8'(i));
            pop_one();
        end
        @(negedge clk);
        chk("coinc_empty", valid, 0);

        // reset in the middle of a frame
        ferr_cnt = 0;
        fork
            send(8'hFF, 1'b1);
            begin
                idle(30);
                #1 rst = 1'b1;
                @(negedge clk);
                chk("mid_rst_valid", valid, 0);
                chk("mid_rst_data", data, 0);
                chk("mid_rst_ferr", ferr, 0);
                chk("mid_rst_ovr", ovr, 0);
                @(posedge clk);
                #1 rst = 1'b0;
            end
        join
        idle(10);
        @(negedge clk);
        chk("post_rst_valid", valid, 0);
        send(8'h5A, 1'b1);
        idle(4);
        @(negedge clk);
        chk("post_rst_data", data, 8'h5A);
        chk("post_rst_ferr", ferr_cnt, 0);
        pop_one();
        @(negedge clk);
        chk("post_rst_empty", valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver feeding the LEG core's UART peripheral from the top-level `rx` pin. It synchronises the asynchronous line and detects and validates start bits. It samples 8N1 frames at mid-bit and queues received bytes in a small FIFO. The core's load path drains the FIFO through a valid/ready handshake. Framing and overrun errors are reported to the peripheral's status register.

## Interface
- `CLKS_PER_BIT`, default 868, i_clk cycles per bit (100 MHz / 115200); must be ≥ 4.
- `FIFO_DEPTH`, default 4, receive FIFO entries; power of two, ≥ 2.

- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset, asynchronous, active-high.
- `rx`  in  1  serial line, idle high, asynchronous to i_clk.
- `o_data`  out  8  byte at FIFO head; valid only while o_valid=1.
- `o_valid`  out  1  FIFO non-empty.
- `i_ready`  in  1  consumer pops the head when o_valid & i_ready.
- `o_frame_err`  out  1  one-cycle pulse, stop bit sampled low.
- `o_overrun`  out  1  sticky; a byte was dropped because the FIFO was full.
- `i_clr_err`  in  1  clears o_overrun.

## Operation
- Input path: 2-flop synchroniser, reset to 1. All decisions use the synchronised `rx_s`.
- State machine: IDLE, START, DATA, STOP, WAIT_HIGH.
- Bit counter: width $clog2(CLKS_PER_BIT). Bit index: 3 bits.
- IDLE: on `rx_s`=0, go to START and load the counter with CLKS_PER_BIT/2 − 1 (integer division).
- START: when the counter hits 0, sample `rx_s`.
  - If 1: false start, return to IDLE. No output.
  - If 0: go to DATA with the counter reloaded to CLKS_PER_BIT − 1 and the index set to 0.
- DATA: on each counter expiry, shift `rx_s` in LSB first and reload the counter. After bit 7, go to STOP.
- STOP: on expiry, sample `rx_s`.
  - If 1: push the byte to the FIFO and return to IDLE.
  - If 0: pulse o_frame_err, discard the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx_s`=1, then IDLE. A held-low line (break) produces exactly one frame_err.
- FIFO: circular buffer with read/write pointers one bit wider than the index. Full = MSBs differ and the index bits are equal.
- Push while full:
  - Without a pop in the same cycle: byte dropped, o_overrun set.
  - With a same-cycle pop: push accepted, no overrun.
- Pop on empty is impossible (o_valid=0); i_ready is ignored then.
- o_overrun: set has priority over i_clr_err in the same cycle.
- o_data is read combinationally from the head entry.

## Timing
- Reset values: o_valid=0, o_overrun=0, o_frame_err=0, o_data=0. State IDLE, pointers 0, synchroniser flops 1.
- Reset mid-frame aborts the frame immediately. After release the receiver re-arms in IDLE. If `rx` is still low after release, that is treated as a new start edge.
- Start detection latency: 2 cycles (synchroniser) from the `rx` falling edge.
- Sample points: start bit CLKS_PER_BIT/2 cycles after detection; data bit k a further (k+1)·CLKS_PER_BIT cycles after that.
- Push occurs on the stop-sample cycle. o_valid rises on the next cycle.
- o_frame_err is high for exactly the cycle after the failing stop sample.
- Pop: the head advances on the clock edge where o_valid & i_ready. o_data/o_valid update the next cycle.
- Throughput: back-to-back frames (no idle gap) are received. IDLE is re-entered at the stop sample, half a bit before the stop bit ends.

## Test plan
- CLKS_PER_BIT=8, send 0xA5, i_ready=0 → o_valid=1 with o_data=0xA5 at about 9.5 bit times after the edge; no errors.
- Line-low glitch of 3 cycles → no byte, no frame_err, receiver back in IDLE.
- Frame 0x3C with stop bit 0 → one-cycle o_frame_err, FIFO stays empty. Holding rx low for 40 cycles → no further pulses.
- FIFO_DEPTH=4, i_ready=0, send 0x01..0x05 → bytes 0x01..0x04 queued, o_overrun=1. Drain with i_ready=1 → reads 0x01,0x02,0x03,0x04, then o_valid=0. Pulse i_clr_err → o_overrun=0.
- Full FIFO, 5th stop sample coincides with a pop → no overrun. Reads yield 0x02..0x05.
- Assert i_rst during DATA of frame 0xFF, release, send 0x5A → only 0x5A received, all outputs 0 during reset.
